// File: rtl/seg_scan_controller.sv
// 4-digit 7-segment scan sequencer with frame-aligned BCD snapshot and dark interval per slot.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
    parameter int DIV_WIDTH   = 17,
    parameter int DEAD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       upd_req,
    input  logic [3:0] digit3_in,
    input  logic [3:0] digit2_in,
    input  logic [3:0] digit1_in,
    input  logic [3:0] digit0_in,
    output logic       upd_ack,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [1:0] selector,
    output logic [3:0] an,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ON
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DEAD_LIM = DIV_WIDTH'(DEAD_CYCLES);
    localparam logic [DIV_WIDTH-1:0] CNT_MAX  = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [1:0]           r_sel;
    logic [1:0]           w_sel_nxt;
    logic [3:0]           r_an;
    logic [3:0]           w_an_nxt;
    logic [15:0]          r_digits;
    logic [15:0]          w_digits_nxt;
    logic                 r_ack;
    logic                 w_ack_nxt;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 w_wrap;
    logic                 w_boundary;
    logic [3:0]           w_blank;

    always_comb begin
        w_wrap     = (r_state != IDLE) && (r_cnt == CNT_MAX);
        w_boundary = en && ((r_state == IDLE) || (w_wrap && (r_sel == 2'd3)));
    end

    // Next state is computed from the next selector/snapshot so that anode and
    // selector always change on the same edge.
    always_comb begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = '0;
        w_sel_nxt    = '0;
        w_ack_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        w_digits_nxt = r_digits;
        if (en) begin
            if (r_state != IDLE) begin
                w_cnt_nxt  = r_cnt + 1'b1;
                w_sel_nxt  = w_wrap ? r_sel + 2'd1 : r_sel;
                w_tick_nxt = w_wrap && (r_sel == 2'd3);
            end
            if (w_boundary && upd_req) begin
                w_digits_nxt = {digit3_in, digit2_in, digit1_in, digit0_in};
                w_ack_nxt    = 1'b1;
            end
            w_state_nxt = (w_cnt_nxt < DEAD_LIM) ? DEAD : ON;
        end
    end

    always_comb begin
        w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank[3] = (w_digits_nxt[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (w_digits_nxt[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (w_digits_nxt[7:4] == 4'd0);
`else
        w_blank = '0;
`endif
        if ((w_state_nxt == ON) && !w_blank[w_sel_nxt]) begin
            w_an_nxt = ~(4'b0001 << w_sel_nxt);
        end else begin
            w_an_nxt = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_an     <= 4'hF;
            r_digits <= '0;
            r_ack    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_an     <= w_an_nxt;
            r_digits <= w_digits_nxt;
            r_ack    <= w_ack_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    assign upd_ack    = r_ack;
    assign digit3     = r_digits[15:12];
    assign digit2     = r_digits[11:8];
    assign digit1     = r_digits[7:4];
    assign digit0     = r_digits[3:0];
    assign selector   = r_sel;
    assign an         = r_an;
    assign frame_tick = r_tick;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Sequences the 4-digit BCD select mux and the common-anode strobes of the 7-segment display.
- Snapshots four BCD digits from the sensor datapath at frame boundaries using a req/ack handshake.
- Drives the mux selector from the snapshot and time-multiplexes the anodes with a dark (anti-ghost) interval at the start of every digit slot.

Parameters:
- DIV_WIDTH, 17, width of the slot counter; one digit slot = 2^DIV_WIDTH clk cycles.
- DEAD_CYCLES, 64, cycles at the start of each slot with all anodes off. Legal range 0 .. 2^DIV_WIDTH-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; low = display dark, counters cleared.
- upd_req  in  1  level request to load new digits; held high until upd_ack.
- digit3_in, digit2_in, digit1_in, digit0_in  in  4 each  BCD digits from the datapath.
- upd_ack  out  1  one-cycle pulse: digits latched on this edge.
- digit3, digit2, digit1, digit0  out  4 each  snapshot digits, feeding the mux data inputs.
- selector  out  2  mux select, equal to the active digit index.
- an  out  4  anode enables, active low; an[k] lights digit k.
- frame_tick  out  1  one-cycle pulse when selector wraps from 3 to 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, selector=0, an=4'hF.
  - digit3..0=0, upd_ack=0, frame_tick=0.
- FSM states: IDLE, DEAD, ON. All outputs are registered.
- IDLE:
  - Entered whenever en=0, checked at every clock edge.
  - cnt=0, selector=0, an=4'hF.
- IDLE->DEAD on the first edge with en=1. This edge is a frame boundary.
- Slot counting:
  - cnt increments every cycle while en=1.
  - At cnt=2^DIV_WIDTH-1, cnt wraps to 0 and selector increments mod 4 on the same edge.
- DEAD vs ON:
  - State is DEAD while cnt<DEAD_CYCLES, otherwise ON.
  - With DEAD_CYCLES=0, DEAD is never visited; ON persists across slots.
- Anodes:
  - DEAD: an=4'hF.
  - ON: an = ~(4'b0001<<selector), unless that digit is blanked (see Optional Feature).
  - an is always consistent with selector in the same cycle. There is never a cycle with a new selector and an old anode.
- Frame boundary: the edge where selector goes 3->0 via wrap, or the IDLE->DEAD edge.
  - frame_tick pulses only on the 3->0 wrap.
- Snapshot handshake:
  - If upd_req=1 at a frame boundary, digit*_in are copied into digit3..0 on that edge and upd_ack=1 for exactly that next cycle.
  - Digits never change mid-frame.
  - If upd_req is still high at the next boundary, a new load and ack occur.
- Simultaneous events:
  - en falling on a wrap edge: IDLE wins; no frame_tick, no snapshot.
  - upd_req rising mid-frame: waits for the next boundary.
- Reset mid-frame: immediate dark display (an=4'hF); snapshot is cleared to 0.
- en toggles: cnt and selector restart from 0. Snapshot digits are retained across en toggles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) is blanked when snapshot digit k==0 and all higher snapshot digits ==0.
  - A blanked digit keeps an=4'hF for its whole slot.
  - Digit0 is never blanked, so 0000 displays "0".
  - selector timing and frame_tick are unchanged.
- Undefined: all four digits always light during ON.

Test Plan (DIV_WIDTH=4, DEAD_CYCLES=2):
- Reset release, en=1 -> slot pattern per digit:
  - cycles 0-1: an=F.
  - cycles 2-15: an=E with selector=0.
  - selector=1 at cycle 16, an=D from cycle 18.
  - frame_tick at cycle 64.
- upd_req=1 with digits 9,8,7,6 asserted at cycle 20 -> no load before cycle 64; digit3..0=9,8,7,6 and upd_ack=1 for one cycle at cycle 64.
- en=0 at cycle 40 (selector=2) -> next cycle an=F, selector=0, cnt=0. Re-enable -> restart in DEAD at selector 0; old digits retained.
- rst_n pulsed low mid-ON of digit 3 -> an=F and digits=0 asynchronously, without waiting for a clock.
- LEADING_ZERO_BLANK_EN with snapshot 0,0,4,2 -> digits 3 and 2 held at F; digit1 an=D; digit0 an=E. Snapshot 0,0,0,0 -> only digit0 lights.
- DEAD_CYCLES=0 -> an never 4'hF while en=1. Snapshot 0,0,4,2 without the macro -> all four anodes cycle E,D,B,7.
